// File: rtl/q2_ctrl_pkg.sv
// Shared types and encodings for the Q2 instruction sequencer.
// This package holds the state and panel enums, the opcodes, the X mux selects and the strobe bundle.
package q2_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_HALT  = 3'd0,
        ST_FETCH = 3'd1,
        ST_DEREF = 3'd2,
        ST_LOAD  = 3'd3,
        ST_EXEC  = 3'd4,
        ST_ALU   = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        PNL_IDLE = 2'd0,
        PNL_DEP  = 2'd1,
        PNL_INC  = 2'd2
    } panel_t;

    localparam logic [2:0] OP_NOR = 3'd0;
    localparam logic [2:0] OP_ADD = 3'd1;
    localparam logic [2:0] OP_SHF = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_LDA = 3'd4;
    localparam logic [2:0] OP_STA = 3'd5;
    localparam logic [2:0] OP_JMP = 3'd6;
    localparam logic [2:0] OP_JNC = 3'd7;

    localparam logic [1:0] XH_DBUS  = 2'd0;
    localparam logic [1:0] XH_ZERO  = 2'd1;
    localparam logic [1:0] XH_P     = 2'd2;
    localparam logic [1:0] XH_SHIFT = 2'd3;
    localparam logic       XL_DBUS  = 1'b0;
    localparam logic       XL_SHIFT = 1'b1;

    typedef struct packed {
        logic       rdp;
        logic       rdx;
        logic       rda;
        logic       wro;
        logic       wra;
        logic       wrx;
        logic       wrp;
        logic       wrm;
        logic       incp;
        logic       wrf;
        logic [1:0] xh_sel;
        logic       xl_sel;
    } strobe_t;

    // Ops 0-4 need an operand fetched into X; STA/JMP/JNC go straight to EXEC.
    function automatic state_t decode_op(input logic [2:0] op);
        return (op <= OP_LDA) ? ST_LOAD : ST_EXEC;
    endfunction

endpackage

// File: rtl/q2_panel_oneshot.sv
// Front-panel switch conditioner: two-flop synchroniser followed by a rising-edge detector.
// The pulse output is high for exactly one clock per low-to-high transition of sw.
module q2_panel_oneshot (
    input  logic clk,
    input  logic rst_n,
    input  logic sw,
    output logic pulse
);

    logic [2:0] sync_q;
    logic [2:0] sync_d;

    always_comb begin
        sync_d = {sync_q[1:0], sw};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 3'b000;
        end else begin
            sync_q <= sync_d;
        end
    end

    // sync_q[1] is the first metastability-safe sample and sync_q[2] is its previous value.
    assign pulse = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/q2_sequencer.sv
// Q2 instruction sequencer: HALT/FETCH/DEREF/LOAD/EXEC/ALU state machine plus front-panel control.
// Every strobe is decoded from the next state and registered, so the outputs change only on clock edges.
module q2_sequencer
    import q2_ctrl_pkg::*;
#(
    parameter int WIDTH = 12,
    parameter int DIGIT = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic       step,
    input  logic       incp_sw,
    input  logic       dep_sw,
    input  logic [2:0] ir_op,
    input  logic       ir_deref,
    input  logic       ir_x0,
    input  logic       flag,
    input  logic       alu_cout,
    output logic       rdp,
    output logic       rdx,
    output logic       rda,
    output logic       wro,
    output logic       wra,
    output logic       wrx,
    output logic       wrp,
    output logic       wrm,
    output logic       incp,
    output logic       wrf,
    output logic       fout,
    output logic [1:0] xh_sel,
    output logic       xl_sel,
    output logic       halted
);

    localparam int ALU_CYCLES = WIDTH / DIGIT;
    localparam int CW = (ALU_CYCLES > 1) ? $clog2(ALU_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(ALU_CYCLES - 1);

    state_t        state_q, state_d;
    logic          phase_q, phase_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    op_q, op_d;
    panel_t        pnl_q, pnl_d;
    logic          step_pend_q, step_pend_d;
    strobe_t       str_q, str_d;
    logic          halted_q, halted_d;

    logic step_pulse, incp_pulse, dep_pulse;

    // The shift direction bit steers the datapath shifter directly; the sequencer does not need it.
    logic unused_x0;
    assign unused_x0 = ir_x0;

    q2_panel_oneshot u_step_os (.clk(clk), .rst_n(rst_n), .sw(step),    .pulse(step_pulse));
    q2_panel_oneshot u_incp_os (.clk(clk), .rst_n(rst_n), .sw(incp_sw), .pulse(incp_pulse));
    q2_panel_oneshot u_dep_os  (.clk(clk), .rst_n(rst_n), .sw(dep_sw),  .pulse(dep_pulse));

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        pnl_d       = pnl_q;
        step_pend_d = step_pend_q;

        case (state_q)
            ST_HALT: begin
                case (pnl_q)
                    PNL_DEP: pnl_d = PNL_INC;
                    PNL_INC: pnl_d = PNL_IDLE;
                    default: begin
                        if (dep_pulse) begin
                            pnl_d = PNL_DEP;
                        end else if (incp_pulse) begin
                            pnl_d = PNL_INC;
                        end
                    end
                endcase
                if (step_pulse) begin
                    step_pend_d = 1'b1;
                end
                // A step caught during a deposit waits in step_pend until the panel sequence is idle.
                if (pnl_q == PNL_IDLE && pnl_d == PNL_IDLE &&
                    (run || step_pulse || step_pend_q)) begin
                    state_d     = ST_FETCH;
                    phase_d     = 1'b0;
                    step_pend_d = 1'b0;
                end
            end
            ST_FETCH: begin
                phase_d = ~phase_q;
                if (phase_q) begin
                    op_d    = ir_op;
                    state_d = ir_deref ? ST_DEREF : decode_op(ir_op);
                end
            end
            ST_DEREF: begin
                phase_d = ~phase_q;
                if (phase_q) begin
                    state_d = decode_op(op_q);
                end
            end
            ST_LOAD: begin
                phase_d = ~phase_q;
                if (phase_q) begin
                    state_d = (op_q == OP_LDA) ? ST_EXEC : ST_ALU;
                end
            end
            ST_EXEC: begin
                phase_d = ~phase_q;
                if (phase_q) begin
                    state_d = run ? ST_FETCH : ST_HALT;
                end
            end
            ST_ALU: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = run ? ST_FETCH : ST_HALT;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_HALT;
                phase_d = 1'b0;
                cnt_d   = '0;
            end
        endcase

        // Strobes for the cycle about to begin, registered below.
        str_d    = '0;
        halted_d = (state_d == ST_HALT);
        case (state_d)
            ST_HALT: begin
                if (pnl_d == PNL_DEP) begin
                    str_d.rdp = 1'b1;
                    str_d.wrm = 1'b1;
                end else if (pnl_d == PNL_INC) begin
                    str_d.incp = 1'b1;
                end
            end
            ST_FETCH: begin
                str_d.rdp = 1'b1;
                if (phase_d) begin
                    str_d.wro    = 1'b1;
                    str_d.wrx    = 1'b1;
                    str_d.incp   = 1'b1;
                    str_d.xh_sel = XH_P;
                end
            end
            ST_DEREF, ST_LOAD: begin
                str_d.rdx = 1'b1;
                if (phase_d) begin
                    str_d.wrx    = 1'b1;
                    str_d.xh_sel = XH_DBUS;
                    str_d.xl_sel = XL_DBUS;
                end
            end
            ST_EXEC: begin
                if (phase_d) begin
                    case (op_d)
                        OP_LDA: str_d.wra = 1'b1;
                        OP_STA: begin
                            str_d.rda = 1'b1;
                            str_d.wrm = 1'b1;
                        end
                        OP_JMP: str_d.wrp = 1'b1;
                        OP_JNC: str_d.wrp = ~flag;
                        default: ;
                    endcase
                end
            end
            ST_ALU: begin
                str_d.xh_sel = XH_SHIFT;
                str_d.xl_sel = XL_SHIFT;
                str_d.wra    = 1'b1;
                str_d.wrx    = 1'b1;
                str_d.wrf    = (cnt_d == CNT_LAST) && (op_d <= OP_AND);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_HALT;
            phase_q     <= 1'b0;
            cnt_q       <= '0;
            op_q        <= OP_NOR;
            pnl_q       <= PNL_IDLE;
            step_pend_q <= 1'b0;
            str_q       <= '0;
            halted_q    <= 1'b1;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            pnl_q       <= pnl_d;
            step_pend_q <= step_pend_d;
            str_q       <= str_d;
            halted_q    <= halted_d;
        end
    end

    assign rdp    = str_q.rdp;
    assign rdx    = str_q.rdx;
    assign rda    = str_q.rda;
    assign wro    = str_q.wro;
    assign wra    = str_q.wra;
    assign wrx    = str_q.wrx;
    assign wrp    = str_q.wrp;
    assign wrm    = str_q.wrm;
    assign incp   = str_q.incp;
    assign wrf    = str_q.wrf;
    assign xh_sel = str_q.xh_sel;
    assign xl_sel = str_q.xl_sel;
    assign halted = halted_q;
    // During a shift the digit ALU reports the shifted-out bit on alu_cout, so one path serves every ALU op.
    assign fout   = str_q.wrf & alu_cout;

endmodule

// File: tb/tb_q2_sequencer.sv
// Self-checking bench for q2_sequencer (WIDTH=12, DIGIT=4 giving three ALU cycles).
// Expected per-cycle strobe vectors are queued from a small instruction model and popped at each negedge.
module tb_q2_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       run = 1'b0, step = 1'b0, incp_sw = 1'b0, dep_sw = 1'b0;
    logic [2:0] ir_op = 3'd0;
    logic       ir_deref = 1'b0, ir_x0 = 1'b0, flag = 1'b0, alu_cout = 1'b0;
    logic       rdp, rdx, rda, wro, wra, wrx, wrp, wrm, incp, wrf, fout, xl_sel, halted;
    logic [1:0] xh_sel;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic       halted, rdp, rdx, rda, wro, wra, wrx, wrp, wrm, incp, wrf, fout;
        logic [1:0] xh;
        logic       xl;
    } obs_t;

    obs_t exp_q[$];

    q2_sequencer #(.WIDTH(12), .DIGIT(4)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .step(step), .incp_sw(incp_sw), .dep_sw(dep_sw),
        .ir_op(ir_op), .ir_deref(ir_deref), .ir_x0(ir_x0), .flag(flag), .alu_cout(alu_cout),
        .rdp(rdp), .rdx(rdx), .rda(rda), .wro(wro), .wra(wra), .wrx(wrx), .wrp(wrp), .wrm(wrm),
        .incp(incp), .wrf(wrf), .fout(fout), .xh_sel(xh_sel), .xl_sel(xl_sel), .halted(halted)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired: got timeout required completion");
        $fatal(1, "watchdog");
    end

    function automatic obs_t sample();
        obs_t o;
        o.halted = halted; o.rdp = rdp; o.rdx = rdx; o.rda = rda; o.wro = wro; o.wra = wra;
        o.wrx = wrx; o.wrp = wrp; o.wrm = wrm; o.incp = incp; o.wrf = wrf; o.fout = fout;
        o.xh = xh_sel; o.xl = xl_sel;
        return o;
    endfunction

    function automatic obs_t halt_v();
        obs_t e = '0;
        e.halted = 1'b1;
        return e;
    endfunction

    // Reference cycle sequence of one instruction starting at FETCH phase 0.
    task automatic push_instr(input logic [2:0] op, input logic deref, input logic flg, input logic cout);
        obs_t e;
        e = '0; e.rdp = 1; exp_q.push_back(e);
        e.wro = 1; e.wrx = 1; e.incp = 1; e.xh = 2'd2; exp_q.push_back(e);
        if (deref) begin
            e = '0; e.rdx = 1; exp_q.push_back(e);
            e.wrx = 1; exp_q.push_back(e);
        end
        if (op <= 3'd4) begin
            e = '0; e.rdx = 1; exp_q.push_back(e);
            e.wrx = 1; exp_q.push_back(e);
        end
        if (op <= 3'd3) begin
            for (int k = 0; k < 3; k++) begin
                e = '0; e.xh = 2'd3; e.xl = 1; e.wra = 1; e.wrx = 1;
                if (k == 2) begin e.wrf = 1; e.fout = cout; end
                exp_q.push_back(e);
            end
        end else begin
            e = '0; exp_q.push_back(e);
            case (op)
                3'd4: e.wra = 1;
                3'd5: begin e.rda = 1; e.wrm = 1; end
                3'd6: e.wrp = 1;
                default: e.wrp = ~flg;
            endcase
            exp_q.push_back(e);
        end
    endtask

    task automatic test_reset();
        obs_t o, e;
        repeat (2) @(negedge clk);
        o = sample(); e = halt_v();
        checks++;
        if (o !== e) begin errors++; $display("FAIL reset_hold got %h required %h", o, e); end
        rst_n = 1'b1;
        exp_q.push_back(halt_v()); exp_q.push_back(halt_v());
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            o = sample(); e = exp_q.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("FAIL reset_idle[%0d] got %h required %h", i, o, e); end
        end
    endtask

    task automatic test_jmp();
        obs_t o, e;
        int n;
        ir_op = 3'd6; ir_deref = 1'b0; flag = 1'b0; run = 1'b1;
        push_instr(3'd6, 1'b0, 1'b0, 1'b0);
        push_instr(3'd6, 1'b0, 1'b0, 1'b0);
        exp_q.push_back(halt_v());
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            o = sample(); e = exp_q.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("FAIL jmp[%0d] got %h required %h", i, o, e); end
            if (i == 4) run = 1'b0;
        end
    endtask

    task automatic test_alu();
        logic [2:0] ops[3]   = '{3'd1, 3'd2, 3'd3};
        logic       drf[3]   = '{1'b1, 1'b0, 1'b0};
        logic       couts[3] = '{1'b1, 1'b1, 1'b0};
        obs_t o, e;
        int n;
        for (int t = 0; t < 3; t++) begin
            ir_op = ops[t]; ir_deref = drf[t]; alu_cout = couts[t]; ir_x0 = t[0]; run = 1'b1;
            push_instr(ops[t], drf[t], 1'b0, couts[t]);
            exp_q.push_back(halt_v());
            n = exp_q.size();
            for (int i = 0; i < n; i++) begin
                @(negedge clk);
                o = sample(); e = exp_q.pop_front();
                checks++;
                if (o !== e) begin errors++; $display("FAIL alu_op%0d[%0d] got %h required %h", ops[t], i, o, e); end
                if (i == 0) run = 1'b0;
            end
        end
        alu_cout = 1'b0;
    endtask

    task automatic test_jnc();
        obs_t o, e;
        int n;
        for (int t = 0; t < 2; t++) begin
            ir_op = 3'd7; ir_deref = 1'b0; flag = (t == 0); run = 1'b1;
            push_instr(3'd7, 1'b0, (t == 0), 1'b0);
            exp_q.push_back(halt_v());
            n = exp_q.size();
            for (int i = 0; i < n; i++) begin
                @(negedge clk);
                o = sample(); e = exp_q.pop_front();
                checks++;
                if (o !== e) begin errors++; $display("FAIL jnc_f%0d[%0d] got %h required %h", flag, i, o, e); end
                if (i == 0) run = 1'b0;
            end
        end
        flag = 1'b0;
    endtask

    task automatic test_panel();
        obs_t o, e, dep_v, inc_v;
        int n;
        dep_v = halt_v(); dep_v.rdp = 1; dep_v.wrm = 1;
        inc_v = halt_v(); inc_v.incp = 1;
        // t=0 deposit alone, t=1 deposit with inc-P, t=2 inc-P alone
        for (int t = 0; t < 3; t++) begin
            dep_sw = (t != 2); incp_sw = (t != 0);
            exp_q.push_back(halt_v()); exp_q.push_back(halt_v());
            if (t != 2) exp_q.push_back(dep_v);
            exp_q.push_back(inc_v);
            exp_q.push_back(halt_v()); exp_q.push_back(halt_v());
            n = exp_q.size();
            for (int i = 0; i < n; i++) begin
                @(negedge clk);
                o = sample(); e = exp_q.pop_front();
                checks++;
                if (o !== e) begin errors++; $display("FAIL panel%0d[%0d] got %h required %h", t, i, o, e); end
            end
            dep_sw = 1'b0; incp_sw = 1'b0;
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic test_run_drop_alu();
        obs_t o, e;
        int n;
        ir_op = 3'd0; ir_deref = 1'b0; alu_cout = 1'b1; run = 1'b1;
        push_instr(3'd0, 1'b0, 1'b0, 1'b1);
        exp_q.push_back(halt_v()); exp_q.push_back(halt_v());
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            o = sample(); e = exp_q.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("FAIL run_drop[%0d] got %h required %h", i, o, e); end
            if (i == 5) run = 1'b0;
        end
        alu_cout = 1'b0;
    endtask

    task automatic test_step_sta();
        obs_t o, e;
        int n;
        ir_op = 3'd5; ir_deref = 1'b0; step = 1'b1;
        exp_q.push_back(halt_v()); exp_q.push_back(halt_v());
        push_instr(3'd5, 1'b0, 1'b0, 1'b0);
        exp_q.push_back(halt_v()); exp_q.push_back(halt_v());
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            o = sample(); e = exp_q.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("FAIL step_sta[%0d] got %h required %h", i, o, e); end
        end
        step = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_step_during_deposit();
        obs_t o, e;
        int n;
        ir_op = 3'd6; ir_deref = 1'b0; step = 1'b1; dep_sw = 1'b1;
        exp_q.push_back(halt_v()); exp_q.push_back(halt_v());
        e = halt_v(); e.rdp = 1; e.wrm = 1; exp_q.push_back(e);
        e = halt_v(); e.incp = 1; exp_q.push_back(e);
        exp_q.push_back(halt_v());
        push_instr(3'd6, 1'b0, 1'b0, 1'b0);
        exp_q.push_back(halt_v());
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            o = sample(); e = exp_q.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("FAIL step_dep[%0d] got %h required %h", i, o, e); end
        end
        step = 1'b0; dep_sw = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset_mid_exec();
        obs_t o, e;
        ir_op = 3'd5; ir_deref = 1'b0; step = 1'b1;
        repeat (6) @(negedge clk);
        o = sample();
        checks++;
        if (o.wrm !== 1'b1) begin errors++; $display("FAIL mid_exec_wrm got %b required 1", o.wrm); end
        rst_n = 1'b0;
        #1;
        o = sample(); e = halt_v();
        checks++;
        if (o !== e) begin errors++; $display("FAIL async_reset got %h required %h", o, e); end
        step = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back(halt_v()); exp_q.push_back(halt_v()); exp_q.push_back(halt_v());
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            o = sample(); e = exp_q.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("FAIL post_reset[%0d] got %h required %h", i, o, e); end
        end
    endtask

    initial begin
        test_reset();
        test_jmp();
        test_alu();
        test_jnc();
        test_panel();
        test_run_drop_alu();
        test_step_sta();
        test_step_during_deposit();
        test_reset_mid_exec();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
